// File: rtl/microwave_pkg.sv
// Shared constants for the microwave cook-time controller: state encodings,
// BCD digit limits and the quick-start increment.
package microwave_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned BCD_W   = 4;

  localparam logic [STATE_W-1:0] IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] COOKING = 2'd1;
  localparam logic [STATE_W-1:0] PAUSED  = 2'd2;
  localparam logic [STATE_W-1:0] DONE    = 2'd3;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_MAX      = 9;
  localparam int unsigned ADD_SECONDS  = 30;

  typedef struct packed {
    logic [BCD_W-1:0] minutes;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_time_t;

endpackage

// File: rtl/bcd_time_counter.sv
// M:SS BCD time register with keypad shift-in, clear, 1 s decrement with
// borrow and a saturating add of ADD_SECONDS. Operation priority: clear > dec > add > shift.
module bcd_time_counter
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [BCD_W-1:0] digit,
  input  logic             dec,
  input  logic             add,
  output logic [BCD_W-1:0] seconds_ones,
  output logic [BCD_W-1:0] seconds_tens,
  output logic [BCD_W-1:0] minutes,
  output logic             zero_c,
  output logic             last_sec_c
);

  localparam int unsigned ADD_ONES = ADD_SECONDS % 10;
  localparam int unsigned ADD_TENS = ADD_SECONDS / 10;

  bcd_time_t  time_q, time_d, dec_t, add_t;
  logic [4:0] ones_sum, tens_sum, min_sum;
  logic       ones_cy, tens_cy;

  // One-second decrement with borrow across units, tens and minutes
  always_comb begin
    dec_t = time_q;
    if (time_q.ones != 4'd0) begin
      dec_t.ones = time_q.ones - 4'd1;
    end else begin
      dec_t.ones = 4'd9;
      if (time_q.tens != 4'd0) begin
        dec_t.tens = time_q.tens - 4'd1;
      end else begin
        dec_t.tens    = 4'(SEC_TENS_MAX);
        dec_t.minutes = time_q.minutes - 4'd1;
      end
    end
  end

  // Add ADD_SECONDS with BCD carry, clamping to the largest displayable time
  always_comb begin
    ones_sum      = 5'(time_q.ones) + 5'(ADD_ONES);
    ones_cy       = (ones_sum > 5'd9);
    tens_sum      = 5'(time_q.tens) + 5'(ADD_TENS) + 5'(ones_cy);
    tens_cy       = (tens_sum > 5'(SEC_TENS_MAX));
    min_sum       = 5'(time_q.minutes) + 5'(tens_cy);
    add_t.ones    = ones_cy ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    add_t.tens    = tens_cy ? 4'(tens_sum - 5'(SEC_TENS_MAX + 1)) : tens_sum[3:0];
    add_t.minutes = min_sum[3:0];
    if (min_sum > 5'(MIN_MAX)) begin
      add_t.minutes = 4'(MIN_MAX);
      add_t.tens    = 4'(SEC_TENS_MAX);
      add_t.ones    = 4'd9;
    end
  end

  always_comb begin
    time_d = time_q;
    if (clear) begin
      time_d = '0;
    end else if (dec) begin
      time_d = dec_t;
    end else if (add) begin
      time_d = add_t;
    end else if (shift && (digit <= 4'd9) && (time_q.ones <= 4'(SEC_TENS_MAX))) begin
      time_d.minutes = time_q.tens;
      time_d.tens    = time_q.ones;
      time_d.ones    = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  assign seconds_ones = time_q.ones;
  assign seconds_tens = time_q.tens;
  assign minutes      = time_q.minutes;
  assign zero_c       = (time_q == '0);
  assign last_sec_c   = (time_q.minutes == 4'd0) && (time_q.tens == 4'd0) && (time_q.ones == 4'd1);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: oven FSM, 1 s prescaler and registered output decode.
// Define QUICK_START_EN to enable the 0:30 quick start and +30 s while cooking.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [BCD_W-1:0]   digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  output logic [BCD_W-1:0]   seconds_ones,
  output logic [BCD_W-1:0]   seconds_tens,
  output logic [BCD_W-1:0]   minutes,
  output logic               mag_on,
  output logic               lamp_on,
  output logic               done_beep,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned          PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               mag_q, lamp_q, beep_q;
  logic               cnt_clear, cnt_shift, cnt_dec, cnt_add;
  logic               zero_c, last_sec_c, tick_c;

  bcd_time_counter u_time (
    .clk          (clk),
    .reset        (reset),
    .clear        (cnt_clear),
    .shift        (cnt_shift),
    .digit        (digit),
    .dec          (cnt_dec),
    .add          (cnt_add),
    .seconds_ones (seconds_ones),
    .seconds_tens (seconds_tens),
    .minutes      (minutes),
    .zero_c       (zero_c),
    .last_sec_c   (last_sec_c)
  );

  assign tick_c = (presc_q == PRESC_LAST);

  // Next state and counter control; prescaler is zero whenever not cooking
  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    cnt_clear = 1'b0;
    cnt_shift = 1'b0;
    cnt_dec   = 1'b0;
    cnt_add   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop_clear) begin
          cnt_clear = 1'b1;
        end else if (start && door_closed && !zero_c) begin
          state_d = COOKING;
`ifdef QUICK_START_EN
        end else if (start && door_closed) begin
          cnt_add = 1'b1;
          state_d = COOKING;
`endif
        end else if (digit_valid) begin
          cnt_shift = 1'b1;
        end
      end
      COOKING: begin
        if (stop_clear || !door_closed) begin
          state_d = PAUSED;
`ifdef QUICK_START_EN
        end else if (start) begin
          cnt_add = 1'b1;
          presc_d = presc_q;
`endif
        end else if (tick_c) begin
          cnt_dec = 1'b1;
          if (last_sec_c) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      PAUSED: begin
        if (stop_clear) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (start && door_closed) begin
          state_d = COOKING;
        end
      end
      default: begin
        if (stop_clear || !door_closed) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      mag_q   <= 1'b0;
      lamp_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mag_q   <= (state_d == COOKING);
      lamp_q  <= (state_d == COOKING) || (state_d == PAUSED) || !door_closed;
      beep_q  <= (state_d == DONE);
    end
  end

  assign state     = state_q;
  assign mag_on    = mag_q;
  assign lamp_on   = lamp_q;
  assign done_beep = beep_q;

endmodule
